// File: rtl/aes_result_monitor.sv
// Passive monitor: captures result words written to a memory window and compares them with exp_data.
// Optional macro AES_MON_REWRITE_FAIL_EN: a second write to an already-captured word fails the run.
module aes_result_monitor #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0120,
    parameter int unsigned NUM_WORDS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [32*NUM_WORDS-1:0] exp_data,
    input  logic                    mem_valid,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    input  logic                    trap,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic                    trap_seen,
    output logic [NUM_WORDS-1:0]    match_mask,
    output logic [32*NUM_WORDS-1:0] captured_data,
    output logic [31:0]             cycle_count
);

    localparam int unsigned IdxW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [31:0] Span    = 32'(4 * NUM_WORDS);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StCheck,
        StPass,
        StFail,
        StTmo
    } state_e;

    state_e               state_q;
    logic [NUM_WORDS-1:0] written_q;

    logic                 wr_hs;
    logic                 hit;
    logic                 completes;
    logic [31:0]          offset;
    logic [IdxW-1:0]      hit_idx;
    logic [NUM_WORDS-1:0] written_nxt;
    logic [NUM_WORDS-1:0] match_nxt;

    always_comb begin
        wr_hs       = mem_valid & mem_ready & (mem_wstrb != 4'h0);
        offset      = mem_addr - BASE_ADDR;
        // offset check alone would wrap for addresses below BASE_ADDR
        hit         = wr_hs && (mem_addr[1:0] == 2'b00) && (mem_addr >= BASE_ADDR)
                      && (offset < Span);
        hit_idx     = offset[IdxW+1:2];
        written_nxt = written_q;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (hit && (hit_idx == IdxW'(i))) begin
                written_nxt[i] = 1'b1;
            end
        end
        completes = hit && (&written_nxt);
        for (int i = 0; i < NUM_WORDS; i++) begin
            match_nxt[i] = (captured_data[32*i +: 32] == exp_data[32*i +: 32]);
        end
    end

`ifdef AES_MON_REWRITE_FAIL_EN
    logic rewrite;
    assign rewrite = |(written_q & ~(written_nxt ^ written_q) & written_nxt & hit_onehot());

    function automatic logic [NUM_WORDS-1:0] hit_onehot();
        logic [NUM_WORDS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            oh[i] = hit && (hit_idx == IdxW'(i));
        end
        return oh;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            written_q     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            trap_seen     <= 1'b0;
            match_mask    <= '0;
            captured_data <= '0;
            cycle_count   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StPass, StFail, StTmo: begin
                    if (start) begin
                        state_q       <= StArmed;
                        written_q     <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        timeout       <= 1'b0;
                        trap_seen     <= 1'b0;
                        match_mask    <= '0;
                        captured_data <= '0;
                        cycle_count   <= '0;
                    end
                end
                StArmed: begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (hit && (hit_idx == IdxW'(i)) && mem_wstrb[b]) begin
                                captured_data[32*i + 8*b +: 8] <= mem_wdata[8*b +: 8];
                            end
                        end
                    end
                    written_q <= written_nxt;
                    if (trap && !completes) begin
                        trap_seen <= 1'b1;
                    end
`ifdef AES_MON_REWRITE_FAIL_EN
                    if (rewrite) begin
                        fail    <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StFail;
                    end else
`endif
                    if (completes) begin
                        state_q <= StCheck;
                    end else if (trap) begin
                        fail    <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StFail;
                    end else if (cycle_count == TmoLast) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StTmo;
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                StCheck: begin
                    match_mask <= match_nxt;
                    done       <= 1'b1;
                    if (&match_nxt) begin
                        pass    <= 1'b1;
                        state_q <= StPass;
                    end else begin
                        fail    <= 1'b1;
                        state_q <= StFail;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_result_monitor.sv
// Directed bench for aes_result_monitor; honours AES_MON_REWRITE_FAIL_EN when defined.
module tb_aes_result_monitor;

`ifdef AES_MON_REWRITE_FAIL_EN
    localparam bit RwFail = 1'b1;
`else
    localparam bit RwFail = 1'b0;
`endif
    localparam logic [127:0] Exp = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

    logic         clk = 1'b0;
    logic         reset, start, trap;
    logic [127:0] exp_data;
    logic         mem_valid, mem_ready;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         done, pass, fail, timeout, trap_seen;
    logic [3:0]   match_mask;
    logic [127:0] captured_data;
    logic [31:0]  cycle_count;
    logic [2:0]   st;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    aes_result_monitor #(
        .BASE_ADDR      (32'h0000_0120),
        .NUM_WORDS      (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .exp_data      (exp_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .trap          (trap),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .trap_seen     (trap_seen),
        .match_mask    (match_mask),
        .captured_data (captured_data),
        .cycle_count   (cycle_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic v, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        mem_valid = v;
        mem_ready = r;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        tick();
        mem_valid = 1'b0;
        mem_ready = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, a, d, 4'hF);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, 128'({done, pass, fail, timeout, trap_seen}), 128'(5'b00000));
        check({tag, "_mask"}, 128'(match_mask), 128'(0));
        check({tag, "_capt"}, captured_data, 128'(0));
        check({tag, "_count"}, 128'(cycle_count), 128'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; trap = 1'b0; exp_data = Exp;
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (2) tick();
        reset = 1'b0;
        check_zero("reset");

        // Matching result: done two edges after the final write
        pulse_start();
        check("arm_count", 128'(cycle_count), 128'(0));
        wr(32'h120, 32'h70b4c55a);
        wr(32'h124, 32'hd8cdb780);
        wr(32'h128, 32'h6a7b0430);
        wr(32'h12C, 32'h69c4e0d8);
        check("t1_done_early", 128'(done), 128'(0));
        tick();
        check("t1_status", 128'({done, pass, fail, timeout, trap_seen}), 128'(5'b11000));
        check("t1_mask", 128'(match_mask), 128'(4'hF));
        check("t1_capt", captured_data, Exp);

        // One corrupted word
        pulse_start();
        check_zero("t2_rearm");
        wr(32'h120, 32'h70b4c55a);
        wr(32'h124, 32'hd8cdb780);
        wr(32'h128, 32'h6a7b0431);
        wr(32'h12C, 32'h69c4e0d8);
        tick();
        check("t2_status", 128'({done, pass, fail, timeout, trap_seen}), 128'(5'b10100));
        check("t2_mask", 128'(match_mask), 128'(4'hB));

        // Timeout with a start pulse in ARMED that must be ignored
        pulse_start();
        wr(32'h120, 32'h70b4c55a);
        wr(32'h124, 32'hd8cdb780);
        wr(32'h128, 32'h6a7b0430);
        pulse_start();
        n = 4;
        check("t3_count_mid", 128'(cycle_count), 128'(4));
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("t3_edges", 128'(n), 128'(100));
        check("t3_status", 128'({done, pass, fail, timeout, trap_seen}), 128'(5'b10010));
        check("t3_count", 128'(cycle_count), 128'(99));
        check("t3_mask", 128'(match_mask), 128'(0));

        // Byte strobes, ignored misaligned/out-of-range/non-handshake cycles
        pulse_start();
        bus(1'b1, 1'b1, 32'h121, 32'h11111111, 4'hF);
        bus(1'b1, 1'b1, 32'h130, 32'h22222222, 4'hF);
        bus(1'b1, 1'b0, 32'h12C, 32'h33333333, 4'hF);
        bus(1'b1, 1'b1, 32'h12C, 32'h44444444, 4'h0);
        check("t4_ignored", captured_data, 128'(0));
        bus(1'b1, 1'b1, 32'h120, 32'hFFFFFF5a, 4'h1);
        bus(1'b1, 1'b1, 32'h120, 32'hFFFFc5FF, 4'h2);
        bus(1'b1, 1'b1, 32'h120, 32'hFFb4FFFF, 4'h4);
        bus(1'b1, 1'b1, 32'h120, 32'h70FFFFFF, 4'h8);
        wr(32'h124, 32'hd8cdb780);
        wr(32'h128, 32'h6a7b0430);
        wr(32'h12C, 32'h69c4e0d8);
        tick();
        check("t4_status", 128'({done, pass, fail, timeout, trap_seen}),
              RwFail ? 128'(5'b10100) : 128'(5'b11000));
        check("t4_capt", captured_data, RwFail ? 128'(32'h0000c55a) : Exp);

        // Trap after two words, then reset during a re-armed run
        pulse_start();
        wr(32'h120, 32'h70b4c55a);
        wr(32'h124, 32'hd8cdb780);
        trap = 1'b1;
        tick();
        trap = 1'b0;
        check("t5_status", 128'({done, pass, fail, timeout, trap_seen}), 128'(5'b10101));
        check("t5_mask", 128'(match_mask), 128'(0));
        pulse_start();
        check("t5_rearm", 128'({done, fail, trap_seen}), 128'(3'b000));
        wr(32'h120, 32'h70b4c55a);
        reset = 1'b1; start = 1'b1;
        bus(1'b1, 1'b1, 32'h124, 32'hd8cdb780, 4'hF);
        reset = 1'b0; start = 1'b0;
        check_zero("t5_reset");
        st = dut.state_q;
        check("t5_state", 128'(st), 128'(0));
        wr(32'h120, 32'h70b4c55a);
        check("t5_idle_write", captured_data, 128'(0));

        // Rewrite of word 0 before completion
        pulse_start();
        wr(32'h120, 32'h70b4c55a);
        wr(32'h120, 32'hDEADBEEF);
        check("t6_rewrite_status", 128'({done, pass, fail, timeout, trap_seen}),
              RwFail ? 128'(5'b10100) : 128'(5'b00000));
        check("t6_rewrite_capt", 128'(captured_data[31:0]), 128'(32'hDEADBEEF));
        wr(32'h124, 32'hd8cdb780);
        wr(32'h128, 32'h6a7b0430);
        wr(32'h120, 32'h70b4c55a);
        wr(32'h12C, 32'h69c4e0d8);
        tick();
        check("t6_status", 128'({done, pass, fail, timeout, trap_seen}),
              RwFail ? 128'(5'b10100) : 128'(5'b11000));
        check("t6_mask", 128'(match_mask), RwFail ? 128'(0) : 128'(4'hF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_result_monitor.md
AES_RESULT_MONITOR -- requirements
Module: aes_result_monitor

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0120, byte address of the first result word.
REQ-002 SHALL have parameter NUM_WORDS, default 4, range 1..16, number of 32-bit result words monitored.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, range 1..2^32-1, cycles allowed in ARMED.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  arm/re-arm pulse; exp_data  in  32*NUM_WORDS  expected result, word i at bits [32i+31:32i].
REQ-006 SHALL snoop the native memory bus: mem_valid  in  1; mem_ready  in  1; mem_addr  in  32; mem_wdata  in  32; mem_wstrb  in  4; trap  in  1.
REQ-007 SHALL have outputs: done  out  1; pass  out  1; fail  out  1; timeout  out  1; trap_seen  out  1.
REQ-008 SHALL have outputs: match_mask  out  NUM_WORDS  per-word compare result; captured_data  out  32*NUM_WORDS  captured words; cycle_count  out  32  cycles spent in ARMED.

Function
REQ-009 SHALL implement states IDLE, ARMED, CHECK, PASS, FAIL, TMO.
REQ-010 SHALL be purely passive on the bus; no bus input is driven or delayed.
REQ-011 SHALL define a write handshake as mem_valid & mem_ready & (mem_wstrb != 0) in one cycle.
REQ-012 SHALL treat a handshake as a hit when mem_addr[1:0]==0 and BASE_ADDR <= mem_addr < BASE_ADDR+4*NUM_WORDS; word index = (mem_addr-BASE_ADDR)>>2.
REQ-013 SHALL, in ARMED on a hit, update only the strobed bytes of the indexed captured word and set its written bit.
REQ-014 SHALL ignore hits and misses in all states other than ARMED.
REQ-015 SHALL, on start in IDLE, PASS, FAIL or TMO, enter ARMED, clearing captured_data, written bits, match_mask, cycle_count, trap_seen, done, pass, fail and timeout.
REQ-016 SHALL ignore start while in ARMED or CHECK.
REQ-017 SHALL increment cycle_count once per cycle in ARMED, saturating at 32'hFFFF_FFFF.
REQ-018 SHALL transition ARMED->CHECK on the edge at which all written bits become set.
REQ-019 SHALL, in CHECK, set match_mask[i] = (captured word i == exp_data word i), sampling exp_data in that cycle, and go to PASS if all bits are set, else FAIL.
REQ-020 SHALL assert done and pass (or fail) from the second rising edge after the final write handshake.
REQ-021 SHALL, if trap is high in ARMED with no completing hit in that cycle, set trap_seen and go to FAIL.
REQ-022 SHALL go ARMED->TMO when cycle_count reaches TIMEOUT_CYCLES-1 without completion; TMO asserts done and timeout.
REQ-023 SHALL give priority completing hit > trap > timeout when they coincide in one cycle.
REQ-024 SHALL hold done/pass/fail/timeout/trap_seen/match_mask sticky in PASS, FAIL and TMO until start or reset.
REQ-025 SHALL keep pass, fail and timeout mutually exclusive; done = pass | fail | timeout.

Reset
REQ-026 SHALL, on reset, enter IDLE and clear every output and internal register to 0.
REQ-027 SHALL let reset override start and any bus event in the same cycle, including mid-ARMED.

Configuration
REQ-028 SHALL, with macro AES_MON_REWRITE_FAIL_EN defined, treat a hit to an already-written word while ARMED as an immediate transition to FAIL (match_mask left 0).
REQ-029 SHALL, without AES_MON_REWRITE_FAIL_EN, let a rewrite overwrite the strobed bytes with no error.

Verification
REQ-030 Bench: start, exp=69c4e0d8_6a7b0430_d8cdb780_70b4c55a, writes 0x120=70b4c55a, 0x124=d8cdb780, 0x128=6a7b0430, 0x12C=69c4e0d8 -> pass=1, match_mask=4'hF, done 2 edges after last write.
REQ-031 Bench: same sequence but 0x128=6a7b0431 -> fail=1, match_mask=4'hB, timeout=0.
REQ-032 Bench: TIMEOUT_CYCLES=100, only three words written -> timeout=1, done=1 after 100 ARMED cycles, cycle_count=99.
REQ-033 Bench: byte writes (wstrb=1,2,4,8) building 0x120 plus full words elsewhere, misaligned write to 0x121 and write to 0x130 -> misaligned/out-of-range ignored, pass=1.
REQ-034 Bench: trap high after two words -> fail=1, trap_seen=1; then reset mid-ARMED on re-arm -> all outputs 0, state IDLE.
REQ-035 Bench: second write 0x120=DEADBEEF before completion -> FAIL with AES_MON_REWRITE_FAIL_EN; without it, final 0x120=70b4c55a yields pass=1.
